// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl
//
// Multi-channel push-button front end. Each raw active-low key pin is synchronised,
// debounced with its own stability counter and classified into press, release,
// long-press and auto-repeat pulses. A per-key LED register toggles on every press.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw key pins, 0 = pressed, asynchronous to clk
//   repeat_en    1 = emit key_repeat pulses while a key is held in the long state
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_long     one-cycle pulse when a hold reaches LONG_CYCLES
//   key_repeat   one-cycle pulse every REPEAT_CYCLES while long-held
//   led_out      per-key LED, inverts the cycle after each key_press

module key_debounce_ctrl #(
  parameter int unsigned KEY_NUM       = 4,
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               repeat_en,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat,
  output logic [KEY_NUM-1:0] led_out
);

  localparam int unsigned DB_W     = $clog2(DB_CYCLES);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES
                                                                  : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);

  // Terminal counts; counters clear on reaching these so they never wrap.
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } state_e;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key

    // ------------------------------------------------------------------------
    // Two-flop synchroniser, resets to the released level.
    // ------------------------------------------------------------------------
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= key_in[i];
        sync2_q <= sync1_q;
      end
    end

    // ------------------------------------------------------------------------
    // Debounce: a new level is taken only after DB_CYCLES consecutive samples
    // that differ from the current stable level; any agreeing sample restarts.
    // ------------------------------------------------------------------------
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            accept;
    logic            press_evt, release_evt;

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      accept   = 1'b0;
      if (sync2_q == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
        accept   = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= 1'b1;
        db_cnt_q <= '0;
      end else begin
        stable_q <= stable_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    // Pins are active-low: an accepted 0 is a press, an accepted 1 a release.
    assign press_evt   = accept & ~sync2_q;
    assign release_evt = accept &  sync2_q;

    // ------------------------------------------------------------------------
    // Event FSM. Pulses are registered so they line up with the state change.
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              led_q;

    // State and event registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        hold_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        led_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        hold_q    <= hold_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
        led_q     <= led_q ^ press_q;
      end
    end

    // Next state; a release always wins over a coincident long/repeat.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StIdle: begin
          if (press_evt) state_d = StPressed;
        end
        StPressed: begin
          if (release_evt) begin
            state_d = StIdle;
          end else if (hold_q == LONG_LAST) begin
            state_d = StLong;
          end
        end
        StLong: begin
          if (release_evt) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Hold counter and event pulses.
    always_comb begin
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (press_evt) begin
            press_d = 1'b1;
            hold_d  = '0;
          end
        end
        StPressed: begin
          if (release_evt) begin
            release_d = 1'b1;
            hold_d    = '0;
          end else if (hold_q == LONG_LAST) begin
            long_d = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StLong: begin
          if (release_evt) begin
            release_d = 1'b1;
            hold_d    = '0;
          end else if (!repeat_en) begin
            // Parked at zero so re-enabling waits a full repeat interval.
            hold_d = '0;
          end else if (hold_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: hold_d = '0;
      endcase
    end

    assign key_state[i]   = (state_q != StIdle);
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
    assign led_out[i]     = led_q;

  end : g_key

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Scoreboard bench for key_debounce_ctrl: stimulus pushes expected event records
// (cycle + pulse vectors); a negedge monitor pops one whenever any pulse is seen.

module tb_key_debounce_ctrl;

  localparam int KN   = 4;
  localparam int DB   = 8;
  localparam int LONG = 32;
  localparam int REP  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] key_in;
  logic          repeat_en;
  logic [KN-1:0] key_state, key_press, key_release, key_long, key_repeat, led_out;

  key_debounce_ctrl #(
    .KEY_NUM      (KN),
    .DB_CYCLES    (DB),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .repeat_en  (repeat_en),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // Edge index: value equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] rpt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] l, input logic [3:0] t);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    e.rpt   = t;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  // Monitor: every pulse cycle must match the next expected record exactly.
  always @(negedge clk) begin
    if ((key_press | key_release | key_long | key_repeat) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {16'h0, key_press, key_release, key_long, key_repeat},
              32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_vec", {16'h0, key_press, key_release, key_long, key_repeat},
              {16'h0, mon_e.press, mon_e.rel, mon_e.lng, mon_e.rpt});
      end
    end
  end

  int p;
  int r;

  initial begin
    rst_n     = 1'b0;
    key_in    = 4'hF;
    repeat_en = 1'b1;
    tick();
    tick();
    check("reset_outputs",
          {8'h0, key_state, key_press, key_release, key_long, key_repeat, led_out}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean press and release on key 0.
    key_in[0] = 1'b0;
    push_ev(cyc + DB + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    repeat (20) tick();
    check("clean_state", key_state, 4'b0001);
    check("clean_led", led_out, 4'b0001);
    key_in[0] = 1'b1;
    push_ev(cyc + DB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (20) tick();
    check("clean_rel_state", key_state, 4'b0000);
    check("clean_rel_led", led_out, 4'b0001);
    check("clean_queue", exp_q.size(), 0);

    // Bounce on key 1: 3-cycle runs, then settle low.
    for (int ph = 0; ph < 10; ph++) begin
      key_in[1] = ph[0];
      repeat (3) tick();
    end
    key_in[1] = 1'b0;
    push_ev(cyc + DB + 2, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    repeat (20) tick();
    check("bounce_queue", exp_q.size(), 0);
    check("bounce_state", key_state, 4'b0010);
    check("bounce_led", led_out, 4'b0011);
    key_in[1] = 1'b1;
    push_ev(cyc + DB + 2, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    repeat (20) tick();

    // Glitch of DB-1 cycles on key 2 is discarded.
    key_in[2] = 1'b0;
    repeat (7) tick();
    key_in[2] = 1'b1;
    repeat (20) tick();
    check("glitch_state", key_state, 4'b0000);
    check("glitch_led", led_out, 4'b0011);
    check("glitch_queue", exp_q.size(), 0);

    // Long press with repeat on key 3, released 76 cycles after press.
    repeat_en = 1'b1;
    key_in[3] = 1'b0;
    p = cyc + DB + 2;
    push_ev(p, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_ev(p + LONG, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    for (int k = 1; k <= 5; k++) push_ev(p + LONG + k * REP, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push_ev(p + 76, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    tick_to(p + 50);
    check("long_state", key_state, 4'b1000);
    tick_to(p + 76 - DB - 2);
    key_in[3] = 1'b1;
    repeat (20) tick();
    check("long_queue", exp_q.size(), 0);
    check("long_rel_state", key_state, 4'b0000);
    check("long_led", led_out, 4'b1011);

    // Same hold with repeat disabled: no repeat pulses.
    repeat_en = 1'b0;
    key_in[3] = 1'b0;
    p = cyc + DB + 2;
    push_ev(p, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_ev(p + LONG, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    push_ev(p + 76, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    tick_to(p + 76 - DB - 2);
    key_in[3] = 1'b1;
    repeat (20) tick();
    check("norep_queue", exp_q.size(), 0);
    check("norep_led", led_out, 4'b0011);

    // Clear LEDs, then press keys 0 and 3 on the same edge.
    rst_n = 1'b0;
    tick();
    check("reset_led", led_out, 4'b0000);
    rst_n = 1'b1;
    repeat (3) tick();
    key_in = 4'b0110;
    p = cyc + DB + 2;
    push_ev(p, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    tick_to(p);
    check("simul_led_same_cycle", led_out, 4'b0000);
    check("simul_state", key_state, 4'b1001);
    tick();
    check("simul_led_next", led_out, 4'b1001);
    key_in[0] = 1'b1;
    push_ev(cyc + DB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    push_ev(p + LONG, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    tick_to(p + LONG + 3);
    check("inlong_state", key_state, 4'b1000);
    check("inlong_queue", exp_q.size(), 0);

    // Reset while key 3 is in LONG: outputs drop at once, key re-detected after.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {8'h0, key_state, key_press, key_release, key_long, key_repeat, led_out}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    push_ev(r + DB + 2, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    tick_to(r + DB + 3);
    check("post_reset_led", led_out, 4'b1000);
    check("post_reset_state", key_state, 4'b1000);
    key_in[3] = 1'b1;
    push_ev(cyc + DB + 2, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    repeat (20) tick();
    check("final_queue", exp_q.size(), 0);
    check("final_state", key_state, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
